// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM state encoding and width helpers.
// No logic of its own; latency and backpressure live in the modules that import it.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_GRANT     = 2'd1,
        ST_LAUNCH    = 2'd2,
        ST_WAIT_DONE = 2'd3
    } sched_state_e;

    // A single requester still needs a 1-bit id field.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: rotate the requests so ptr lands on bit 0, take the lowest set bit, map it back.
// Purely combinational, zero latency; it never stalls, an empty request vector just drops gnt_any.
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int IDW = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic [IDW-1:0]     gnt_id,
    output logic               gnt_any
);

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    logic [IDW-1:0]       offset;
    logic [IDW:0]         sum;

    assign req_dbl = {req, req} >> ptr;
    assign req_rot = req_dbl[NUM_REQ-1:0];
    assign gnt_any = |req;

    // Scanning downwards leaves the lowest set position in offset.
    always_comb begin
        offset = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                offset = IDW'(i);
            end
        end
    end

    always_comb begin
        sum = {1'b0, ptr} + {1'b0, offset};
        if (sum >= (IDW + 1)'(NUM_REQ)) begin
            sum = sum - (IDW + 1)'(NUM_REQ);
        end
        gnt_id = sum[IDW-1:0];
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Packet-locked round-robin feeder that shares one UART bit transmitter between NUM_REQ byte sources.
// One byte per DATA_BITS+6 cycles; a requester waits on req_ready until the lock and the transmitter are free.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_BITS = UART_DATA_BITS,
    parameter int MAX_PKT   = 64,
    localparam int IDW  = id_width(NUM_REQ),
    localparam int CNTW = $clog2(MAX_PKT + 1)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
    input  logic [NUM_REQ-1:0]             req_last,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           tx_start,
    output logic [DATA_BITS-1:0]           tx_data,
    input  logic                           tx_done,
    output logic                           busy,
    output logic                           grant_valid,
    output logic [IDW-1:0]                 grant_id,
    output logic                           pkt_err
);

    sched_state_e         state;
    logic                 lock;
    logic [IDW-1:0]       ptr;
    logic [IDW-1:0]       owner;
    logic [CNTW-1:0]      byte_cnt;
    logic [DATA_BITS-1:0] hold;
    logic                 last_q;
    logic [NUM_REQ-1:0]   ready_q;
    logic                 start_q;
    logic                 err_q;

    logic [IDW-1:0]       arb_id;
    logic                 arb_any;
    logic [IDW-1:0]       ptr_next;
    logic [DATA_BITS-1:0] data_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign data_arr[g] = req_data[g*DATA_BITS +: DATA_BITS];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req     (req_valid),
        .ptr     (ptr),
        .gnt_id  (arb_id),
        .gnt_any (arb_any)
    );

    assign ptr_next = (owner == IDW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= ST_IDLE;
            lock     <= 1'b0;
            ptr      <= '0;
            owner    <= '0;
            byte_cnt <= '0;
            hold     <= '0;
            last_q   <= 1'b0;
            ready_q  <= '0;
            start_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            ready_q <= '0;
            start_q <= 1'b0;
            err_q   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // A held lock ignores everyone but the owner, even if the owner is idle.
                    if (lock) begin
                        if (req_valid[owner]) begin
                            ready_q <= NUM_REQ'(1) << owner;
                            state   <= ST_GRANT;
                        end
                    end else if (arb_any) begin
                        owner   <= arb_id;
                        lock    <= 1'b1;
                        ready_q <= NUM_REQ'(1) << arb_id;
                        state   <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    hold     <= data_arr[owner];
                    last_q   <= req_last[owner];
                    byte_cnt <= byte_cnt + 1'b1;
                    start_q  <= 1'b1;
                    state    <= ST_LAUNCH;
                end
                ST_LAUNCH: begin
                    state <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (tx_done) begin
                        state <= ST_IDLE;
                        if (last_q || byte_cnt == CNTW'(MAX_PKT)) begin
                            lock     <= 1'b0;
                            ptr      <= ptr_next;
                            byte_cnt <= '0;
                            err_q    <= !last_q;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready   = ready_q;
    assign tx_start    = start_q;
    assign tx_data     = hold;
    assign pkt_err     = err_q;
    assign grant_valid = lock;
    assign grant_id    = owner;
    assign busy        = (state != ST_IDLE) || lock;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed-plus-random bench for uart_tx_sched with a behavioural transmitter and a packet-level scheduling model.
module tb_uart_tx_sched;

    localparam int NUM = 4;
    localparam int DW  = 8;
    localparam int MAXP = 4;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } ent_t;

    logic              clk;
    logic              reset;
    logic [NUM-1:0]    req_valid;
    logic [NUM*DW-1:0] req_data;
    logic [NUM-1:0]    req_last;
    logic [NUM-1:0]    req_ready;
    logic              tx_start;
    logic [DW-1:0]     tx_data;
    logic              tx_done;
    logic              busy;
    logic              grant_valid;
    logic [1:0]        grant_id;
    logic              pkt_err;

    uart_tx_sched #(
        .NUM_REQ   (NUM),
        .DATA_BITS (DW),
        .MAX_PKT   (MAXP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_done     (tx_done),
        .busy        (busy),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .pkt_err     (pkt_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    ent_t rq [NUM][$];
    bit   en [NUM];
    logic [NUM-1:0] rdy_prev;

    bit          tx_busy;
    int          tx_k;
    logic [9:0]  frame;

    int rdy_id[$];
    int rdy_cyc[$];
    int st_cyc[$];
    int st_dat[$];
    int err_cyc[$];
    int done_cyc[$];
    logic pin_log[$];

    int exp_id[$];
    int exp_dat[$];
    int exp_err;
    int m_ptr, m_owner, m_cnt;
    bit m_lock;

    int rr_exp[5] = '{0, 1, 2, 3, 0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic int at(input int q[$], input int k);
        return (k < q.size()) ? q[k] : -1;
    endfunction

    function automatic int pending();
        int n = 0;
        for (int i = 0; i < NUM; i++) n += rq[i].size();
        return n;
    endfunction

    task automatic push(input int i, input logic [DW-1:0] d, input logic l);
        ent_t e;
        e.d = d;
        e.l = l;
        rq[i].push_back(e);
    endtask

    task automatic clear_logs();
        rdy_id.delete(); rdy_cyc.delete(); st_cyc.delete(); st_dat.delete();
        err_cyc.delete(); done_cyc.delete(); pin_log.delete();
    endtask

    task automatic drive();
        for (int i = 0; i < NUM; i++) begin
            if (en[i] && rq[i].size() > 0) begin
                req_valid[i] = 1'b1;
                req_data[i*DW +: DW] = rq[i][0].d;
                req_last[i] = rq[i][0].l;
            end else begin
                req_valid[i] = 1'b0;
                req_data[i*DW +: DW] = '0;
                req_last[i] = 1'b0;
            end
        end
    endtask

    // One clock: retire last cycle's accepted byte, step the transmitter, log DUT outputs, drive requesters.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        tx_done = 1'b0;
        if (!reset) begin
            tx_busy = 1'b0;
            tx_k = 0;
            rdy_prev = '0;
        end else begin
            for (int i = 0; i < NUM; i++)
                if (rdy_prev[i] && rq[i].size() > 0) void'(rq[i].pop_front());
            if (tx_busy) begin
                tx_k++;
                if (tx_k <= DW + 2) begin
                    pin_log.push_back(frame[tx_k-1]);
                end else begin
                    tx_done = 1'b1;
                    tx_busy = 1'b0;
                    done_cyc.push_back(cyc);
                end
            end
        end
        if (req_ready != '0) begin
            chk("ready_onehot", 32'($onehot(req_ready)), 1);
            for (int i = 0; i < NUM; i++)
                if (req_ready[i]) begin
                    rdy_id.push_back(i);
                    rdy_cyc.push_back(cyc);
                end
        end
        rdy_prev = req_ready;
        if (tx_start) begin
            chk("start_while_in_flight", 32'(tx_busy), 0);
            st_cyc.push_back(cyc);
            st_dat.push_back(int'(tx_data));
            tx_busy = 1'b1;
            tx_k = 0;
            frame = {1'b1, tx_data, 1'b0};
        end
        if (pkt_err) err_cyc.push_back(cyc);
        drive();
    endtask

    // Packet-level expectation, assuming every queued byte is presented from the start.
    task automatic predict();
        ent_t cp [NUM][$];
        ent_t e;
        int total = 0;
        for (int i = 0; i < NUM; i++) begin
            cp[i] = rq[i];
            total += cp[i].size();
        end
        exp_id.delete();
        exp_dat.delete();
        exp_err = 0;
        while (total > 0) begin
            if (!m_lock) begin
                for (int k = 0; k < NUM; k++) begin
                    if (!m_lock && cp[(m_ptr + k) % NUM].size() > 0) begin
                        m_owner = (m_ptr + k) % NUM;
                        m_lock = 1'b1;
                    end
                end
            end
            if (cp[m_owner].size() == 0) break;
            e = cp[m_owner].pop_front();
            total--;
            exp_id.push_back(m_owner);
            exp_dat.push_back(int'(e.d));
            m_cnt++;
            if (e.l || m_cnt == MAXP) begin
                if (!e.l) exp_err++;
                m_lock = 1'b0;
                m_ptr = (m_owner + 1) % NUM;
                m_cnt = 0;
            end
        end
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while ((pending() > 0 || busy !== 1'b0) && n < budget) begin
            tick();
            n++;
        end
        chk({tag, ".timeout"}, 32'(n < budget), 1);
    endtask

    task automatic compare_logs(input string tag, input bit spacing);
        int bad = 0;
        int sbad = 0;
        chk({tag, ".grants"}, rdy_id.size(), exp_id.size());
        chk({tag, ".starts"}, st_dat.size(), exp_dat.size());
        for (int k = 0; k < exp_id.size(); k++)
            if (at(rdy_id, k) != exp_id[k] || at(st_dat, k) != exp_dat[k]) bad++;
        chk({tag, ".order_data"}, bad, 0);
        chk({tag, ".pkt_err_count"}, err_cyc.size(), exp_err);
        if (spacing) begin
            for (int k = 1; k < st_cyc.size(); k++)
                if (st_cyc[k] - st_cyc[k-1] != DW + 6) sbad++;
            chk({tag, ".spacing"}, sbad, 0);
        end
    endtask

    int t0, n, bad, stall_bad, nb;
    logic [0:9] obs_pins;
    logic [0:9] exp_pins;

    initial begin
        reset = 1'b0;
        req_valid = '0; req_data = '0; req_last = '0; tx_done = 1'b0;
        rdy_prev = '0; tx_busy = 1'b0; tx_k = 0; frame = '0;
        m_ptr = 0; m_owner = 0; m_cnt = 0; m_lock = 1'b0;
        for (int i = 0; i < NUM; i++) en[i] = 1'b1;
        repeat (3) tick();
        chk("reset.outputs", 32'({req_ready, tx_start, tx_data, busy, grant_valid, grant_id, pkt_err}), 0);
        reset = 1'b1;
        tick();

        // Single byte with pin pattern and per-stage timing.
        push(0, 8'hA5, 1'b1);
        predict();
        clear_logs();
        tick();
        t0 = cyc;
        while (cyc < t0 + 13) tick();
        chk("s1.lock_at_done", 32'(grant_valid), 1);
        tick();
        chk("s1.lock_after_done", 32'(grant_valid), 0);
        chk("s1.busy_after_done", 32'(busy), 0);
        chk("s1.ready_cycle", at(rdy_cyc, 0), t0 + 1);
        chk("s1.start_cycle", at(st_cyc, 0), t0 + 2);
        chk("s1.tx_data", at(st_dat, 0), 32'hA5);
        chk("s1.done_cycle", at(done_cyc, 0), t0 + 13);
        exp_pins = 10'b0101001011;
        for (int k = 0; k < 10; k++) obs_pins[k] = (k < pin_log.size()) ? pin_log[k] : 1'bx;
        chk("s1.pin_pattern", 32'(obs_pins), 32'(exp_pins));
        compare_logs("s1", 1'b1);

        // Packet lock: requester 1 sends three bytes while requester 2 waits.
        for (int b = 0; b < 3; b++) push(1, 8'($urandom_range(0, 255)), b == 2);
        push(2, 8'($urandom_range(0, 255)), 1'b1);
        predict();
        clear_logs();
        tick();
        wait_idle("s2", 120);
        compare_logs("s2", 1'b1);
        chk("s2.r2_after_packet", at(rdy_id, 3), 2);
        chk("s2.r2_ready_after_third_start", 32'(at(rdy_cyc, 3) > at(st_cyc, 2)), 1);

        // Force release: requester 3 streams eight bytes without last, requester 0 valid throughout.
        for (int b = 0; b < 8; b++) push(3, 8'($urandom_range(0, 255)), 1'b0);
        push(0, 8'($urandom_range(0, 255)), 1'b1);
        predict();
        clear_logs();
        tick();
        wait_idle("s4", 200);
        compare_logs("s4", 1'b1);
        chk("s4.err_after_4th_done", at(err_cyc, 0), at(done_cyc, 3) + 1);
        chk("s4.next_grant_r0", at(rdy_id, 4), 0);
        chk("s4.grant_after_release", at(rdy_cyc, 4), at(done_cyc, 3) + 2);

        // Round robin from ptr 0 with every requester valid.
        push(0, 8'($urandom_range(0, 255)), 1'b1);
        for (int i = 1; i < NUM; i++) push(i, 8'($urandom_range(0, 255)), 1'b1);
        push(0, 8'($urandom_range(0, 255)), 1'b1);
        predict();
        clear_logs();
        tick();
        wait_idle("s3", 120);
        compare_logs("s3", 1'b1);
        bad = 0;
        for (int k = 0; k < 5; k++) if (at(rdy_id, k) != rr_exp[k]) bad++;
        chk("s3.rr_order", bad, 0);

        // Owner stalls between bytes while requester 0 is waiting.
        push(2, 8'($urandom_range(0, 255)), 1'b0);
        push(2, 8'($urandom_range(0, 255)), 1'b1);
        push(0, 8'($urandom_range(0, 255)), 1'b1);
        predict();
        clear_logs();
        tick();
        n = 0;
        while (rdy_id.size() == 0 && n < 30) begin
            tick();
            n++;
        end
        en[2] = 1'b0;
        stall_bad = 0;
        repeat (40) begin
            tick();
            if (busy !== 1'b1 || grant_valid !== 1'b1 || req_ready !== '0) stall_bad++;
        end
        chk("s5.lock_held_in_stall", stall_bad, 0);
        chk("s5.no_grant_in_stall", rdy_id.size(), 1);
        chk("s5.owner_in_stall", 32'(grant_id), 2);
        en[2] = 1'b1;
        wait_idle("s5", 120);
        compare_logs("s5", 1'b0);

        // Reset during data bit 3, then the next grant searches from ptr 0.
        push(1, 8'($urandom_range(0, 255)), 1'b1);
        clear_logs();
        tick();
        n = 0;
        while (st_cyc.size() == 0 && n < 20) begin
            tick();
            n++;
        end
        repeat (5) tick();
        reset = 1'b0;
        tick();
        tick();
        chk("s6.outputs_in_reset", 32'({req_ready, tx_start, tx_data, busy, grant_valid, grant_id, pkt_err}), 0);
        reset = 1'b1;
        m_ptr = 0; m_owner = 0; m_cnt = 0; m_lock = 1'b0;
        push(3, 8'($urandom_range(0, 255)), 1'b1);
        push(0, 8'($urandom_range(0, 255)), 1'b1);
        predict();
        clear_logs();
        tick();
        wait_idle("s6", 80);
        compare_logs("s6", 1'b1);
        chk("s6.grant_from_ptr0", at(rdy_id, 0), 0);

        // Random packet mixes, lengths crossing the forced-release limit.
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NUM; i++) begin
                int npk = $urandom_range(0, 2);
                for (int p = 0; p < npk; p++) begin
                    int len = $urandom_range(1, 6);
                    for (int b = 0; b < len; b++) push(i, 8'($urandom_range(0, 255)), b == len - 1);
                end
            end
            if (pending() == 0) push(0, 8'($urandom_range(0, 255)), 1'b1);
            nb = pending();
            predict();
            clear_logs();
            tick();
            wait_idle("s7", nb * (DW + 6) + 60);
            compare_logs("s7", 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
